// File: rtl/eoc_status_pkg.sv
// Shared register map, exit codes and watchdog state type for the EOC status block.
package eoc_status_pkg;

    localparam logic [4:0] STATUS_OFS    = 5'h00;
    localparam logic [4:0] CTRL_OFS      = 5'h04;
    localparam logic [4:0] WDT_LIMIT_OFS = 5'h08;
    localparam logic [4:0] WDT_COUNT_OFS = 5'h0C;
    localparam logic [4:0] SCRATCH_OFS   = 5'h10;

    localparam logic [30:0] EXIT_TIMEOUT = 31'h7FFF_FFFF;

    localparam int CTRL_WDT_EN_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    typedef enum logic [1:0] {IDLE, COUNT, EXPIRED} wdt_state_e;

endpackage

// File: rtl/eoc_wdt_counter.sv
// Watchdog FSM with saturating counter; expire_o flags that the coming edge times out.
module eoc_wdt_counter
    import eoc_status_pkg::*;
#(
    parameter int WDT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             done_i,
    input  logic             sw_done_i,
    input  logic             kick_i,
    input  logic             clear_i,
    input  logic [WDT_W-1:0] limit_i,
    output logic [WDT_W-1:0] count_o,
    output logic             expire_o
);

    localparam logic [WDT_W-1:0] ONE = WDT_W'(1);

    wdt_state_e       state_q, state_d;
    logic [WDT_W-1:0] count_q, count_d, count_inc;
    logic             hit;

    always_comb begin
        count_inc = (&count_q) ? count_q : count_q + ONE;
        hit       = (limit_i == '0) || (count_q == limit_i - ONE);
        state_d   = state_q;
        count_d   = count_q;
        expire_o  = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            if (kick_i) count_d = '0;
            case (state_q)
                IDLE: if (en_i && !done_i && !sw_done_i) state_d = COUNT;
                COUNT: begin
                    // Stopping takes precedence over expiry; a kick restarts the count.
                    if (!en_i || done_i || sw_done_i) begin
                        state_d = IDLE;
                    end else if (!kick_i) begin
                        count_d = count_inc;
                        if (hit) begin
                            state_d  = EXPIRED;
                            expire_o = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/eoc_status_unit.sv
// APB3 end-of-computation status register block polled by the debug host.
// Define EOC_WDT_EN to include the watchdog that forces a timeout exit code.
module eoc_status_unit
    import eoc_status_pkg::*;
#(
    parameter int               ADDR_W        = 12,
    parameter int               WDT_W         = 32,
    parameter logic [WDT_W-1:0] WDT_LIMIT_RST = 32'h00FF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              eoc_o,
    output logic              eoc_pulse_o
);

    logic        access, wr, clear, status_wr, sw_done, expire;
    logic [4:0]  ofs;
    logic [31:0] status_q, status_d, scratch_q, scratch_d;
    logic        eoc_pulse_q, eoc_pulse_d;
    logic        wdt_en_rd;
    logic [31:0] wdt_limit_rd, wdt_count_rd;
    logic        unused_ok;

    assign access    = psel & penable;
    assign wr        = access & pwrite;
    assign ofs       = {paddr[4:2], 2'b00};
    assign clear     = wr && (ofs == CTRL_OFS) && pwdata[CTRL_CLEAR_BIT];
    // STATUS is sticky once done is set; only a clear reopens it.
    assign status_wr = wr && (ofs == STATUS_OFS) && !status_q[31];
    assign sw_done   = status_wr && pwdata[31];

`ifdef EOC_WDT_EN
    logic             wdt_en_q, wdt_en_d;
    logic [WDT_W-1:0] limit_q, limit_d, wdt_count;
    logic             kick;

    assign kick = wr && (ofs == WDT_COUNT_OFS);

    always_comb begin
        wdt_en_d = wdt_en_q;
        limit_d  = limit_q;
        if (wr && ofs == CTRL_OFS)      wdt_en_d = pwdata[CTRL_WDT_EN_BIT];
        if (wr && ofs == WDT_LIMIT_OFS) limit_d  = pwdata[WDT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdt_en_q <= 1'b0;
            limit_q  <= WDT_LIMIT_RST;
        end else begin
            wdt_en_q <= wdt_en_d;
            limit_q  <= limit_d;
        end
    end

    eoc_wdt_counter #(.WDT_W(WDT_W)) u_wdt (
        .clk       (clk),
        .reset     (reset),
        .en_i      (wdt_en_q),
        .done_i    (status_q[31]),
        .sw_done_i (sw_done),
        .kick_i    (kick),
        .clear_i   (clear),
        .limit_i   (limit_q),
        .count_o   (wdt_count),
        .expire_o  (expire)
    );

    assign wdt_en_rd    = wdt_en_q;
    assign wdt_limit_rd = 32'(limit_q);
    assign wdt_count_rd = 32'(wdt_count);
    assign unused_ok    = ^{paddr[ADDR_W-1:5], paddr[1:0]};
`else
    assign expire       = 1'b0;
    assign wdt_en_rd    = 1'b0;
    assign wdt_limit_rd = '0;
    assign wdt_count_rd = '0;
    assign unused_ok    = ^{paddr[ADDR_W-1:5], paddr[1:0], WDT_LIMIT_RST};
`endif

    always_comb begin
        status_d  = status_q;
        scratch_d = scratch_q;
        // Clear beats software done, which beats timeout, which beats a code-only write.
        if (clear)          status_d = '0;
        else if (sw_done)   status_d = pwdata;
        else if (expire)    status_d = {1'b1, EXIT_TIMEOUT};
        else if (status_wr) status_d = pwdata;
        if (wr && ofs == SCRATCH_OFS) scratch_d = pwdata;
        eoc_pulse_d = status_d[31] & ~status_q[31];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_q    <= '0;
            scratch_q   <= '0;
            eoc_pulse_q <= 1'b0;
        end else begin
            status_q    <= status_d;
            scratch_q   <= scratch_d;
            eoc_pulse_q <= eoc_pulse_d;
        end
    end

    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (access) begin
            case (ofs)
                STATUS_OFS:    prdata = status_q;
                CTRL_OFS:      prdata = {31'b0, wdt_en_rd};
                WDT_LIMIT_OFS: prdata = wdt_limit_rd;
                WDT_COUNT_OFS: prdata = wdt_count_rd;
                SCRATCH_OFS:   prdata = scratch_q;
                default:       pslverr = 1'b1;
            endcase
        end
    end

    assign pready      = 1'b1;
    assign eoc_o       = status_q[31];
    assign eoc_pulse_o = eoc_pulse_q;

endmodule
